// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO drain arbiter: FSM encoding and burst length width.
package fifo_arb_pkg;

   localparam logic ARB_IDLE     = 1'b0;
   localparam logic ARB_BURST    = 1'b1;
   localparam int   ARB_LEN_BITS = 8;

   typedef enum logic {
      ST_IDLE  = ARB_IDLE,
      ST_BURST = ARB_BURST
   } arb_state_e;

endpackage

// File: rtl/fifo_drain_arbiter_rr_select.sv
// Rotating priority encoder: picks the first set request after i_last,
// wrapping modulo NUM_CHN, so the most recently served channel goes last.
module rr_select #(
   parameter int NUM_CHN  = 4,
   parameter int CHN_BITS = 2
) (
   input  logic [NUM_CHN-1:0]  i_req,
   input  logic [CHN_BITS-1:0] i_last,
   output logic                o_any,
   output logic [CHN_BITS-1:0] o_sel
);

   logic [CHN_BITS-1:0] w_idx;

   // Scan offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      o_any = |i_req;
      o_sel = '0;
      w_idx = '0;
      for (int k = NUM_CHN; k >= 1; k--) begin
         w_idx = CHN_BITS'((int'(i_last) + k) % NUM_CHN);
         if (i_req[w_idx]) begin
            o_sel = w_idx;
         end else begin
            o_sel = o_sel;
         end
      end
   end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_CHN channel FIFOs into one registered output
// stream with valid/ready backpressure, in bursts of at most MAX_BURST words.
// Optional macro FIFO_ARB_PRIORITY_EN: half-full channels win arbitration.
module fifo_drain_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_CHN    = 4,
   parameter int CHN_BITS   = 2,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CHN-1:0]            chn_nempty,
   input  logic [NUM_CHN-1:0]            chn_half_full,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] chn_data,
   output logic [NUM_CHN-1:0]            chn_re,
   output logic                          dst_valid,
   input  logic                          dst_ready,
   output logic [DATA_WIDTH-1:0]         dst_data,
   output logic [CHN_BITS-1:0]           dst_chn,
   output logic                          dst_last,
   output logic                          burst_done,
   output logic [ARB_LEN_BITS-1:0]       burst_len,
   output logic                          busy
);

   localparam logic [ARB_LEN_BITS-1:0] LAST_CNT = ARB_LEN_BITS'(MAX_BURST - 1);

   arb_state_e              r_state, w_state_nxt;
   logic [CHN_BITS-1:0]     r_last_chn, r_cur, w_sel;
   logic [ARB_LEN_BITS-1:0] r_cnt;
   logic [NUM_CHN-1:0]      w_req;
   logic                    w_any, w_pop, w_end, w_cur_nempty;
   logic [DATA_WIDTH-1:0]   w_chn_word [NUM_CHN];

   for (genvar gi = 0; gi < NUM_CHN; gi++) begin : g_split
      assign w_chn_word[gi] = chn_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef FIFO_ARB_PRIORITY_EN
   logic [NUM_CHN-1:0] w_urgent;
   assign w_urgent = chn_nempty & chn_half_full;
   assign w_req    = (|w_urgent) ? w_urgent : chn_nempty;
`else
   logic w_unused_hf;
   assign w_unused_hf = ^chn_half_full;
   assign w_req       = chn_nempty;
`endif

   rr_select #(
      .NUM_CHN  (NUM_CHN),
      .CHN_BITS (CHN_BITS)
   ) u_rr_select (
      .i_req  (w_req),
      .i_last (r_last_chn),
      .o_any  (w_any),
      .o_sel  (w_sel)
   );

   assign w_cur_nempty = chn_nempty[r_cur];
   assign busy         = (r_state != ST_IDLE) || dst_valid;

   // Next state, pop decision and grant termination.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_end       = 1'b0;
      chn_re      = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_BURST;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BURST: begin
            w_pop         = w_cur_nempty && (!dst_valid || dst_ready);
            chn_re[r_cur] = w_pop;
            if (!w_cur_nempty) begin
               w_end       = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_pop && (r_cnt == LAST_CNT)) begin
               w_end       = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_BURST;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Arbitration state: FSM, granted channel, word count and grant-end report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_last_chn <= CHN_BITS'(NUM_CHN - 1);
         r_cur      <= '0;
         r_cnt      <= '0;
         burst_done <= 1'b0;
         burst_len  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         burst_done <= w_end;
         if ((r_state == ST_IDLE) && w_any) begin
            r_cur <= w_sel;
            r_cnt <= '0;
         end else if (w_pop) begin
            r_cnt <= r_cnt + ARB_LEN_BITS'(1);
         end else begin
            r_cnt <= r_cnt;
         end
         if (w_end) begin
            r_last_chn <= r_cur;
            burst_len  <= w_pop ? (r_cnt + ARB_LEN_BITS'(1)) : r_cnt;
         end else begin
            burst_len  <= '0;
         end
      end
   end

   // One-deep output register: load on pop, drain on ready, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dst_valid <= 1'b0;
         dst_data  <= '0;
         dst_chn   <= '0;
         dst_last  <= 1'b0;
      end else if (w_pop) begin
         dst_valid <= 1'b1;
         dst_data  <= w_chn_word[r_cur];
         dst_chn   <= r_cur;
         dst_last  <= (r_cnt == LAST_CNT);
      end else if (dst_ready) begin
         dst_valid <= 1'b0;
      end else begin
         dst_valid <= dst_valid;
      end
   end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Self-checking bench for fifo_drain_arbiter: channel FIFOs modelled as
// arrays, expected stream computed at burst level from round-robin rules.
module tb_fifo_drain_arbiter;

   localparam int NUM_CHN = 4;
   localparam int CHN_BITS = 2;
   localparam int DW = 16;
   localparam int MB = 8;
   localparam int HF_TH = 10;
   localparam int DEPTH = 64;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NUM_CHN-1:0]     chn_nempty;
   logic [NUM_CHN-1:0]     chn_half_full;
   logic [NUM_CHN*DW-1:0]  chn_data;
   logic [NUM_CHN-1:0]     chn_re;
   logic                   dst_valid;
   logic                   dst_ready;
   logic [DW-1:0]          dst_data;
   logic [CHN_BITS-1:0]    dst_chn;
   logic                   dst_last;
   logic                   burst_done;
   logic [7:0]             burst_len;
   logic                   busy;

   fifo_drain_arbiter #(
      .NUM_CHN(NUM_CHN), .CHN_BITS(CHN_BITS), .DATA_WIDTH(DW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst), .chn_nempty(chn_nempty), .chn_half_full(chn_half_full),
      .chn_data(chn_data), .chn_re(chn_re), .dst_valid(dst_valid), .dst_ready(dst_ready),
      .dst_data(dst_data), .dst_chn(dst_chn), .dst_last(dst_last),
      .burst_done(burst_done), .burst_len(burst_len), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  c;
      logic        l;
   } word_t;

   logic [15:0] fifo_mem [NUM_CHN][DEPTH];
   int rd_ptr [NUM_CHN];
   int wr_ptr [NUM_CHN];
   int errors = 0;
   int checks = 0;
   int ready_pct = 100;
   int cyc = 0;
   int stable_viol = 0;
   int pops_total = 0;
   int m_last = NUM_CHN - 1;
   logic [NUM_CHN-1:0] pop_s = '0;
   logic prev_hold = 1'b0;
   word_t prev_word = '0;
   word_t obs_w[$];
   word_t exp_w[$];
   int    obs_cyc[$];
   logic [7:0] obs_b[$];
   logic [7:0] exp_b[$];

   // Monitor: sample pops, accepted words, grant ends and hold stability mid-cycle.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      pop_s <= chn_re;
      if (!rst) begin
         if ($countones(chn_re) > 1) stable_viol <= stable_viol + 1;
         if (prev_hold && (word_t'({dst_data, dst_chn, dst_last}) !== prev_word))
            stable_viol <= stable_viol + 1;
         if (dst_valid && dst_ready) begin
            obs_w.push_back(word_t'({dst_data, dst_chn, dst_last}));
            obs_cyc.push_back(cyc);
         end
         if (burst_done) obs_b.push_back(burst_len);
      end
      prev_hold <= dst_valid && !dst_ready;
      prev_word <= word_t'({dst_data, dst_chn, dst_last});
   end

   task automatic refresh();
      for (int ch = 0; ch < NUM_CHN; ch++) begin
         chn_nempty[ch] = (rd_ptr[ch] != wr_ptr[ch]);
         chn_half_full[ch] = ((wr_ptr[ch] - rd_ptr[ch]) >= HF_TH);
         chn_data[ch*DW +: DW] = fifo_mem[ch][rd_ptr[ch] % DEPTH];
      end
   endtask

   task automatic push(input int ch, input logic [15:0] w);
      fifo_mem[ch][wr_ptr[ch] % DEPTH] = w;
      wr_ptr[ch]++;
      refresh();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NUM_CHN; ch++) begin
         if (pop_s[ch]) begin
            checks++;
            if (rd_ptr[ch] == wr_ptr[ch]) begin
               errors++;
               $display("FAIL underflow: chn %0d popped while empty (actual pop=1, required 0)", ch);
            end else begin
               rd_ptr[ch]++;
               pops_total++;
            end
         end
      end
      refresh();
      dst_ready = ($urandom_range(99) < ready_pct);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      dst_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      m_last = NUM_CHN - 1;
   endtask

   // Burst-level expectation: each grant takes min(MB, occupancy) words.
   task automatic build_model();
      int r [NUM_CHN];
      int last, sel, n;
      logic [NUM_CHN-1:0] req;
      logic [NUM_CHN-1:0] hf;
      exp_w.delete();
      exp_b.delete();
      for (int ch = 0; ch < NUM_CHN; ch++) r[ch] = rd_ptr[ch];
      last = m_last;
      forever begin
         for (int ch = 0; ch < NUM_CHN; ch++) begin
            req[ch] = (r[ch] != wr_ptr[ch]);
            hf[ch] = req[ch] && ((wr_ptr[ch] - r[ch]) >= HF_TH);
         end
         if (req == '0) break;
`ifdef FIFO_ARB_PRIORITY_EN
         if (hf != '0) req = hf;
`endif
         sel = -1;
         for (int k = 1; k <= NUM_CHN; k++) begin
            if (sel < 0 && req[(last + k) % NUM_CHN]) sel = (last + k) % NUM_CHN;
         end
         n = 0;
         while (n < MB && r[sel] != wr_ptr[sel]) begin
            exp_w.push_back(word_t'({fifo_mem[sel][r[sel] % DEPTH], 2'(sel), (n == MB - 1)}));
            r[sel]++;
            n++;
         end
         exp_b.push_back(8'(n));
         last = sel;
      end
      m_last = last;
   endtask

   task automatic run_drain(input string name);
      int waited;
      logic done;
      build_model();
      obs_w.delete();
      obs_cyc.delete();
      obs_b.delete();
      stable_viol = 0;
      done = 1'b0;
      waited = 0;
      while (!done && waited < 3000) begin
         step();
         waited++;
         done = 1'b1;
         for (int ch = 0; ch < NUM_CHN; ch++) if (rd_ptr[ch] != wr_ptr[ch]) done = 1'b0;
         if (busy) done = 1'b0;
      end
      step(); step(); step();
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: drained=%0d after %0d cycles, required 1", name, done, waited);
      end
      checks++;
      if (obs_w.size() !== exp_w.size()) begin
         errors++;
         $display("FAIL %s word_count: got %0d, required %0d", name, obs_w.size(), exp_w.size());
      end
      for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
         checks++;
         if (obs_w[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL %s word[%0d]: got data=%h chn=%0d last=%0d, required data=%h chn=%0d last=%0d",
                     name, i, obs_w[i].d, obs_w[i].c, obs_w[i].l, exp_w[i].d, exp_w[i].c, exp_w[i].l);
         end
      end
      checks++;
      if (obs_b.size() !== exp_b.size()) begin
         errors++;
         $display("FAIL %s burst_count: got %0d, required %0d", name, obs_b.size(), exp_b.size());
      end
      for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
         checks++;
         if (obs_b[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL %s burst_len[%0d]: got %0d, required %0d", name, i, obs_b[i], exp_b[i]);
         end
      end
      checks++;
      if (stable_viol !== 0) begin
         errors++;
         $display("FAIL %s hold_stability: got %0d violations, required 0", name, stable_viol);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({dst_valid, dst_data, dst_chn, dst_last, burst_done, burst_len, busy, chn_re} !== '0) begin
         errors++;
         $display("FAIL %s: valid=%b data=%h chn=%0d last=%b done=%b len=%0d busy=%b re=%b, required all 0",
                  name, dst_valid, dst_data, dst_chn, dst_last, burst_done, burst_len, busy, chn_re);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_idle_outputs("reset_state");
   endtask

   task automatic test_two_channels();
      do_reset();
      ready_pct = 100;
      for (int i = 0; i < 3; i++) push(0, {4'h0, 12'(i)});
      for (int i = 0; i < 3; i++) push(2, {4'h2, 12'(i)});
      run_drain("two_channels");
      checks++;
      if (obs_w.size() > 0 && obs_w[0].c !== 2'd0) begin
         errors++;
         $display("FAIL two_channels first_chn: got %0d, required 0", obs_w[0].c);
      end
      checks++;
      if (obs_b.size() > 0 && obs_b[0] !== 8'd3) begin
         errors++;
         $display("FAIL two_channels first_len: got %0d, required 3", obs_b[0]);
      end
   endtask

   task automatic test_long_burst();
      do_reset();
      ready_pct = 100;
      for (int i = 0; i < 20; i++) push(1, {4'h1, 12'(i)});
      run_drain("long_burst");
      checks++;
      if (obs_cyc.size() == 20 && (obs_cyc[19] - obs_cyc[0]) !== 21) begin
         errors++;
         $display("FAIL long_burst span: got %0d cycles, required 21", obs_cyc[19] - obs_cyc[0]);
      end
   endtask

   task automatic test_all_channels();
      int order [5];
      order = '{0, 1, 2, 3, 0};
      do_reset();
      ready_pct = 100;
      for (int ch = 0; ch < NUM_CHN; ch++)
         for (int i = 0; i < 20; i++) push(ch, {4'(ch), 12'(i)});
      run_drain("all_channels");
      for (int b = 0; b < 5; b++) begin
         checks++;
         if (obs_w.size() > b * 8 && obs_w[b*8].c !== 2'(order[b])) begin
            errors++;
            $display("FAIL all_channels grant[%0d]: got %0d, required %0d", b, obs_w[b*8].c, order[b]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 8; i++) push(3, {4'h3, 12'(i)});
      ready_pct = 40;
      run_drain("backpressure");
      ready_pct = 100;
      for (int i = 0; i < 8 && i < obs_w.size(); i++) begin
         checks++;
         if (obs_w[i].d !== {4'h3, 12'(i)}) begin
            errors++;
            $display("FAIL backpressure seq[%0d]: got %h, required %h", i, obs_w[i].d, {4'h3, 12'(i)});
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int waited;
      do_reset();
      ready_pct = 100;
      for (int i = 0; i < 10; i++) push(1, {4'h1, 12'(i)});
      pops_total = 0;
      waited = 0;
      while (pops_total < 3 && waited < 50) begin
         step();
         waited++;
      end
      checks++;
      if (pops_total !== 3) begin
         errors++;
         $display("FAIL reset_mid pops: got %0d, required 3", pops_total);
      end
      rst = 1'b1;
      #1;
      check_idle_outputs("reset_mid_async");
      push(0, 16'h0A00);
      push(0, 16'h0A01);
      step();
      step();
      rst = 1'b0;
      m_last = NUM_CHN - 1;
      run_drain("reset_mid_resume");
      checks++;
      if (obs_w.size() > 0 && obs_w[0].c !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid first_chn: got %0d, required 0", obs_w[0].c);
      end
   endtask

   task automatic test_priority();
      logic [1:0] want;
`ifdef FIFO_ARB_PRIORITY_EN
      want = 2'd3;
`else
      want = 2'd0;
`endif
      do_reset();
      ready_pct = 100;
      for (int i = 0; i < 4; i++) push(0, {4'h0, 12'(i + 100)});
      for (int i = 0; i < 12; i++) push(3, {4'h3, 12'(i + 100)});
      run_drain("priority");
      checks++;
      if (obs_w.size() > 0 && obs_w[0].c !== want) begin
         errors++;
         $display("FAIL priority first_chn: got %0d, required %0d", obs_w[0].c, want);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int round = 0; round < 4; round++) begin
         for (int ch = 0; ch < NUM_CHN; ch++) begin
            int n;
            n = $urandom_range(20);
            for (int i = 0; i < n; i++) push(ch, {4'(ch), 12'($urandom)});
         end
         ready_pct = $urandom_range(100, 30);
         run_drain("random");
      end
      ready_pct = 100;
   endtask

   initial begin
      rst = 1'b1;
      dst_ready = 1'b1;
      chn_nempty = '0;
      chn_half_full = '0;
      chn_data = '0;
      for (int ch = 0; ch < NUM_CHN; ch++) begin
         rd_ptr[ch] = 0;
         wr_ptr[ch] = 0;
      end
      test_reset();
      test_two_channels();
      test_long_burst();
      test_all_channels();
      test_backpressure();
      test_reset_mid_burst();
      test_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
